// File: rtl/timer_count_core_if.sv
// Command and display bundle between the stopwatch controller and the MM:SS timer datapath.
// master drives the command and button lines; slave drives the BCD digits and status flags.
interface timer_count_core_if;
   logic       enableCounter;
   logic       forward;
   logic       resetTimer;
   logic       segDemand;
   logic       minDemand;
   logic [3:0] secUnits;
   logic [2:0] secTens;
   logic [3:0] minUnits;
   logic [2:0] minTens;
   logic       tick;
   logic       timeUp;

   modport master (
      output enableCounter, forward, resetTimer, segDemand, minDemand,
      input  secUnits, secTens, minUnits, minTens, tick, timeUp
   );

   modport slave (
      input  enableCounter, forward, resetTimer, segDemand, minDemand,
      output secUnits, secTens, minUnits, minTens, tick, timeUp
   );
endinterface

// File: rtl/timer_count_core.sv
// MM:SS BCD timer: button-driven upward edits in set mode, 1 Hz countdown in run mode.
// All outputs come straight from registers.
module timer_count_core #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic               clk,
   input  logic               reset,
   timer_count_core_if.slave  if_tmr
);
   localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {MODE_IDLE, MODE_SET, MODE_RUN} mode_t;

   logic          r_seg_prev, r_min_prev;
   logic [3:0]    r_sec_u, r_min_u;
   logic [2:0]    r_sec_t, r_min_t;
   logic [PW-1:0] r_presc;
   logic          r_tick, r_time_up;

   mode_t         w_mode;
   logic          w_seg_edge, w_min_edge, w_sec_nz, w_min_nz;
   logic [3:0]    w_sec_u_next, w_min_u_next;
   logic [2:0]    w_sec_t_next, w_min_t_next;
   logic [PW-1:0] w_presc_next;
   logic          w_tick_next, w_time_up_next;

   assign w_seg_edge = if_tmr.segDemand & ~r_seg_prev;
   assign w_min_edge = if_tmr.minDemand & ~r_min_prev;
   assign w_sec_nz   = (r_sec_u != 4'd0) || (r_sec_t != 3'd0);
   assign w_min_nz   = (r_min_u != 4'd0) || (r_min_t != 3'd0);

   always_comb begin
      w_mode = MODE_IDLE;
      if (if_tmr.enableCounter)
         w_mode = if_tmr.forward ? MODE_SET : MODE_RUN;
   end

   always_comb begin
      w_sec_u_next   = r_sec_u;
      w_sec_t_next   = r_sec_t;
      w_min_u_next   = r_min_u;
      w_min_t_next   = r_min_t;
      w_presc_next   = r_presc;
      w_time_up_next = r_time_up;
      w_tick_next    = 1'b0;
      if (if_tmr.resetTimer) begin
         w_sec_u_next   = 4'd0;
         w_sec_t_next   = 3'd0;
         w_min_u_next   = 4'd0;
         w_min_t_next   = 3'd0;
         w_presc_next   = '0;
         w_time_up_next = 1'b0;
      end else begin
         case (w_mode)
            MODE_SET: begin
               // Seconds wrap 59->00 on their own; no carry into minutes while editing.
               w_presc_next = '0;
               if (w_seg_edge) begin
                  if (r_sec_u == 4'd9) begin
                     w_sec_u_next = 4'd0;
                     w_sec_t_next = (r_sec_t == 3'd5) ? 3'd0 : r_sec_t + 3'd1;
                  end else begin
                     w_sec_u_next = r_sec_u + 4'd1;
                  end
               end
               if (w_min_edge) begin
                  if (r_min_u == 4'd9) begin
                     w_min_u_next = 4'd0;
                     w_min_t_next = (r_min_t == 3'd5) ? 3'd0 : r_min_t + 3'd1;
                  end else begin
                     w_min_u_next = r_min_u + 4'd1;
                  end
               end
               if (w_seg_edge || w_min_edge)
                  w_time_up_next = 1'b0;
            end
            MODE_RUN: begin
               if (r_presc == P_LAST) begin
                  w_presc_next = '0;
                  w_tick_next  = 1'b1;
                  if (w_sec_nz) begin
                     if (r_sec_u == 4'd0) begin
                        w_sec_u_next = 4'd9;
                        w_sec_t_next = r_sec_t - 3'd1;
                     end else begin
                        w_sec_u_next = r_sec_u - 4'd1;
                     end
                     if (!w_min_nz && r_sec_t == 3'd0 && r_sec_u == 4'd1)
                        w_time_up_next = 1'b1;
                  end else if (w_min_nz) begin
                     w_sec_u_next = 4'd9;
                     w_sec_t_next = 3'd5;
                     if (r_min_u == 4'd0) begin
                        w_min_u_next = 4'd9;
                        w_min_t_next = r_min_t - 3'd1;
                     end else begin
                        w_min_u_next = r_min_u - 4'd1;
                     end
                  end else begin
                     // Already at 00:00: hold the digits but still step and flag expiry.
                     w_time_up_next = 1'b1;
                  end
               end else begin
                  w_presc_next = r_presc + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg_prev <= 1'b0;
         r_min_prev <= 1'b0;
         r_sec_u    <= 4'd0;
         r_sec_t    <= 3'd0;
         r_min_u    <= 4'd0;
         r_min_t    <= 3'd0;
         r_presc    <= '0;
         r_tick     <= 1'b0;
         r_time_up  <= 1'b0;
      end else begin
         r_seg_prev <= if_tmr.segDemand;
         r_min_prev <= if_tmr.minDemand;
         r_sec_u    <= w_sec_u_next;
         r_sec_t    <= w_sec_t_next;
         r_min_u    <= w_min_u_next;
         r_min_t    <= w_min_t_next;
         r_presc    <= w_presc_next;
         r_tick     <= w_tick_next;
         r_time_up  <= w_time_up_next;
      end
   end

   assign if_tmr.secUnits = r_sec_u;
   assign if_tmr.secTens  = r_sec_t;
   assign if_tmr.minUnits = r_min_u;
   assign if_tmr.minTens  = r_min_t;
   assign if_tmr.tick     = r_tick;
   assign if_tmr.timeUp   = r_time_up;
endmodule

// File: tb/tb_timer_count_core.sv
// Scoreboard bench for timer_count_core: a seconds-level reference model predicts every cycle's display,
// and an independent monitor compares it with the DUT outputs (plus an immediate check on async reset).
module tb_timer_count_core;
   localparam int TD = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   timer_count_core_if tif ();

   timer_count_core #(.TICK_DIV(TD)) dut (
      .clk    (clk),
      .reset  (reset),
      .if_tmr (tif)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int cyc;
      int mm;
      int ss;
      bit tk;
      bit tu;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: time kept as whole minutes/seconds, countdown done on total seconds.
   int m_mm = 0, m_ss = 0, m_ph = 0;
   bit m_tu = 0, m_seg_prev = 0, m_min_prev = 0;

   task automatic push_exp(input bit tk);
      exp_t e;
      e.cyc = cyc_cnt + 1;
      e.mm  = m_mm;
      e.ss  = m_ss;
      e.tk  = tk;
      e.tu  = m_tu;
      sb_q.push_back(e);
   endtask

   task automatic step(input bit en, input bit fw, input bit rt, input bit sg, input bit mn);
      bit se, me, tk;
      int t;
      @(negedge clk);
      #1;
      reset = 1'b0;
      tif.enableCounter = en;
      tif.forward       = fw;
      tif.resetTimer    = rt;
      tif.segDemand     = sg;
      tif.minDemand     = mn;
      se = sg & ~m_seg_prev;
      me = mn & ~m_min_prev;
      m_seg_prev = sg;
      m_min_prev = mn;
      tk = 1'b0;
      if (rt) begin
         m_mm = 0; m_ss = 0; m_ph = 0; m_tu = 1'b0;
      end else if (en && fw) begin
         m_ph = 0;
         if (se) m_ss = (m_ss + 1) % 60;
         if (me) m_mm = (m_mm + 1) % 60;
         if (se || me) m_tu = 1'b0;
      end else if (en) begin
         if (m_ph == TD - 1) begin
            m_ph = 0;
            tk   = 1'b1;
            t    = m_mm * 60 + m_ss;
            if (t > 0) t = t - 1;
            m_mm = t / 60;
            m_ss = t % 60;
            if (t == 0) m_tu = 1'b1;
         end else begin
            m_ph = m_ph + 1;
         end
      end
      push_exp(tk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      tif.enableCounter = 1'b0;
      tif.forward       = 1'b0;
      tif.resetTimer    = 1'b0;
      tif.segDemand     = 1'b0;
      tif.minDemand     = 1'b0;
      m_mm = 0; m_ss = 0; m_ph = 0; m_tu = 1'b0;
      m_seg_prev = 1'b0; m_min_prev = 1'b0;
      push_exp(1'b0);
   endtask

   task automatic press(input bit sg, input bit mn);
      step(1, 1, 0, sg, mn);
      step(1, 1, 0, 0, 0);
   endtask

   task automatic set_time(input int mm, input int ss);
      for (int i = 0; i < mm; i++) press(0, 1);
      for (int i = 0; i < ss; i++) press(1, 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic clear();
      step(1, 1, 1, 0, 0);
   endtask

   // Monitor: compares on every falling edge, and right after any async reset assertion.
   bit   mon_prev_rst = 1'b0;
   exp_t mon_e;
   always @(negedge clk or posedge reset) begin
      if (reset && !mon_prev_rst) begin
         mon_prev_rst = 1'b1;
         #1;
         n_tests++;
         if (tif.secUnits !== 4'd0 || tif.secTens !== 3'd0 || tif.minUnits !== 4'd0 ||
             tif.minTens !== 3'd0 || tif.tick !== 1'b0 || tif.timeUp !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %0d%0d:%0d%0d tick=%0b timeUp=%0b, want 00:00 tick=0 timeUp=0",
                     tif.minTens, tif.minUnits, tif.secTens, tif.secUnits, tif.tick, tif.timeUp);
         end
      end else begin
         mon_prev_rst = reset;
         if (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if (mon_e.cyc != cyc_cnt ||
                tif.secUnits !== 4'(mon_e.ss % 10) || tif.secTens !== 3'(mon_e.ss / 10) ||
                tif.minUnits !== 4'(mon_e.mm % 10) || tif.minTens !== 3'(mon_e.mm / 10) ||
                tif.tick !== mon_e.tk || tif.timeUp !== mon_e.tu) begin
               n_fail++;
               $display("FAIL display cyc=%0d: got %0d%0d:%0d%0d tick=%0b timeUp=%0b, want %02d:%02d tick=%0b timeUp=%0b (exp cyc %0d)",
                        cyc_cnt, tif.minTens, tif.minUnits, tif.secTens, tif.secUnits, tif.tick, tif.timeUp,
                        mon_e.mm, mon_e.ss, mon_e.tk, mon_e.tu, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_cnt);
      $fatal(1, "time limit");
   end

   initial begin
      tif.enableCounter = 1'b0;
      tif.forward       = 1'b0;
      tif.resetTimer    = 1'b0;
      tif.segDemand     = 1'b0;
      tif.minDemand     = 1'b0;

      do_reset();
      idle(2);

      // Async reset in the middle of a countdown from 12:34, then the same via resetTimer.
      set_time(12, 34);
      run(6);
      do_reset();
      idle(3);
      set_time(12, 34);
      run(6);
      step(1, 0, 1, 0, 0);
      idle(2);

      // Seconds wrap with no minute carry; one cycle with both buttons rising.
      repeat (60) press(1, 0);
      press(1, 1);
      repeat (2) press(0, 1);
      idle(2);

      // Borrow across the minute boundary.
      clear();
      set_time(1, 0);
      run(13);

      // Expiry, hold at 00:00, then an edit clears timeUp.
      clear();
      set_time(0, 2);
      run(16);
      press(1, 0);

      // Pause keeps the fractional second.
      clear();
      set_time(0, 10);
      run(2);
      idle(20);
      run(6);

      // Buttons ignored in RUN and IDLE; a level held across SET entry does nothing.
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      run(9);

      // Random segments of mode, buttons and clears, with rare async resets.
      for (int s = 0; s < 200; s++) begin
         int  r, len;
         bit  en, fw;
         r   = $urandom_range(0, 9);
         len = $urandom_range(1, 24);
         en  = (r >= 2);
         fw  = (r >= 2 && r <= 4);
         if ($urandom_range(0, 49) == 0) begin
            do_reset();
         end else begin
            for (int k = 0; k < len; k++)
               step(en, fw, ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
         end
      end

      idle(2);
      repeat (3) @(negedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/timer_count_core.md
# timer_count_core

Datapath end of the stopwatch/timer control interface. Consumes the `enableCounter`/`forward`/`resetTimer` command lines and the `segDemand`/`minDemand` set buttons. Holds the MM:SS time as four BCD digits. Supports setting the time upward in set mode and counting it down at 1 Hz in run mode. Drives the digits to the VGA time renderer and flags expiry.

## Interface
- `TICK_DIV`, 100_000_000, clk cycles per countdown second (≥2); prescaler width = ceil(log2(TICK_DIV)).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enableCounter`  in  1  counter command: active.
- `forward`  in  1  counter command: 1 = set mode (edit), 0 = run mode (countdown).
- `resetTimer`  in  1  synchronous clear command.
- `segDemand`  in  1  seconds-increment button level (already debounced).
- `minDemand`  in  1  minutes-increment button level (already debounced).
- `secUnits`  out  4  seconds ones digit, BCD 0–9.
- `secTens`  out  3  seconds tens digit, 0–5.
- `minUnits`  out  4  minutes ones digit, BCD 0–9.
- `minTens`  out  3  minutes tens digit, 0–5.
- `tick`  out  1  one-cycle pulse on each countdown decrement.
- `timeUp`  out  1  level, time has expired.

## Operation
- Modes, decoded each cycle:
  - IDLE: `enableCounter`=0.
  - SET: `enableCounter`=1 and `forward`=1.
  - RUN: `enableCounter`=1 and `forward`=0.
- Edge detect: registered copies `segPrev`/`minPrev` (reset 0) track the inputs every cycle in all modes.
  - Seconds edge = `segDemand & ~segPrev`.
  - Minutes edge = `minDemand & ~minPrev`.
- Priority, highest first: `reset`, then `resetTimer`, then mode action.
- `resetTimer`=1: digits ← 00:00, prescaler ← 0, `timeUp` ← 0, `tick` ← 0. Edge registers still update.
- SET:
  - A seconds edge increments seconds 00→59 and wraps 59→00, with no carry into minutes.
  - A minutes edge increments minutes 00→59 and wraps 59→00.
  - Both edges in the same cycle increment both fields.
  - Any edit clears `timeUp`. The prescaler is held at 0.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - In a cycle where prescaler = TICK_DIV-1, the next edge wraps the prescaler to 0 and applies one decrement step.
  - Decrement: SS>00 gives SS-1. SS=00 and MM>00 gives SS=59, MM-1. At 00:00, hold.
  - The decrement that produces 00:00 sets `timeUp`. A step taken while already at 00:00 also sets it.
  - Button edges are ignored.
- IDLE: digits, prescaler and `timeUp` hold. This is pause: the fractional second is preserved across stop/start.
- BCD invariant: the unit digit wraps 9→0 with a tens carry/borrow. Tens never exceed 5, so illegal BCD is never produced.

## Timing
- Reset values: all digits 0, `tick`=0, `timeUp`=0, prescaler 0, `segPrev`=`minPrev`=0.
- Every output is a register; there is no combinational input→output path.
- SET edit latency: the button rises in cycle n and the digit changes after edge n (visible in cycle n+1).
- RUN latency: entering RUN with prescaler 0, the first decrement is visible TICK_DIV cycles later. Subsequent decrements come every TICK_DIV cycles.
- `tick`: high for exactly the one cycle in which the new decremented value first appears. It also pulses on the hold step at 00:00.
- `timeUp` rises in the same cycle as the `tick` that shows 00:00. It stays high until `resetTimer`, `reset`, or a SET edit.
- Mode change mid-second: RUN→IDLE→RUN resumes from the retained prescaler value. RUN→SET zeroes the prescaler.
- A button held high across a SET entry produces no increment. It must fall and rise again.
- Async `reset` mid-countdown clears everything immediately. Counting resumes only after deassertion, in RUN, from 00:00.

## Test plan
- Reset/clear: assert `reset` mid-run at 12:34, then release. All outputs read 00:00, `tick`=0, `timeUp`=0. Repeat using `resetTimer` with the same result.
- Set wrap: in SET, give 61 `segDemand` pulses and 3 `minDemand` pulses, including one cycle where both rise together. Display reads 03:01, with no minute carry from the seconds wrap.
- Countdown borrow (TICK_DIV=4): set 01:00 and enter RUN. The first `tick` comes 4 cycles later and shows 00:59. `tick` then repeats every 4 cycles.
- Expiry (TICK_DIV=4): set 00:02 and run. `tick` shows 00:01, then 00:00 with `timeUp`=1 in the same cycle. Further ticks hold 00:00 with `timeUp` still 1. A SET edit clears `timeUp`.
- Pause (TICK_DIV=4): run from 00:10, drop `enableCounter` after 2 cycles for 20 cycles, then resume. The next `tick` arrives 2 cycles after resuming and shows 00:09.
- Ignored inputs: pulse `segDemand` in RUN and in IDLE, and hold `minDemand` high across IDLE→SET entry. Digits are unchanged in all cases.
